// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and types used by the half adder and its lane cell.
package alu_pkg;

    localparam int   HA_MAX_WIDTH = 64;
    localparam logic HA_RESET_VAL = 1'b0;

    // Per-lane result pair; carry sits in the MSB so the pair reads as the 2-bit sum a+b.
    typedef struct packed {
        logic carry;
        logic sum;
    } ha_pair_t;

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder: sum = a ^ b, carry = a & b.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with one-cycle latency.
// Optional macro HALF_ADDER_COMB_OUT_EN exposes the unregistered sum_comb/carry_comb ports.
module half_adder
    import alu_pkg::*;
#(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = HA_RESET_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
`ifdef HALF_ADDER_COMB_OUT_EN
    ,
    output logic [WIDTH-1:0] sum_comb,
    output logic [WIDTH-1:0] carry_comb
`endif
);

    ha_pair_t         pair_s [WIDTH];
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] carry_q;
    logic             valid_d;
    logic             valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (pair_s[i].sum),
            .carry (pair_s[i].carry)
        );
`ifdef HALF_ADDER_COMB_OUT_EN
        assign sum_comb[i]   = pair_s[i].sum;
        assign carry_comb[i] = pair_s[i].carry;
`endif
    end

    // Next-state: capture lane results on in_valid, otherwise hold so idle-cycle X never reaches the flops.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        if (in_valid) begin
            valid_d = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                sum_d[i]   = pair_s[i].sum;
                carry_d[i] = pair_s[i].carry;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Result and valid registers; synchronous reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= {WIDTH{RESET_VAL}};
            carry_q <= {WIDTH{RESET_VAL}};
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a 4-lane and a scalar instance checked against an arithmetic reference.
module tb_half_adder;

    logic       clk;
    logic       reset;
    logic       v4, v1;
    logic [3:0] a4, b4;
    logic [0:0] a1, b1;
    logic       ov4, ov1;
    logic [3:0] s4, c4;
    logic [0:0] s1, c1;
`ifdef HALF_ADDER_COMB_OUT_EN
    logic [3:0] sc4, cc4;
    logic [0:0] sc1, cc1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what each DUT's registered outputs should hold.
    logic [3:0] m_sum4, m_car4;
    logic       m_v4;
    logic [3:0] m_sum1, m_car1;
    logic       m_v1;

    half_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .a(a4), .b(b4),
        .out_valid(ov4), .sum(s4), .carry(c4)
`ifdef HALF_ADDER_COMB_OUT_EN
        , .sum_comb(sc4), .carry_comb(cc4)
`endif
    );

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1),
        .out_valid(ov1), .sum(s1), .carry(c1)
`ifdef HALF_ADDER_COMB_OUT_EN
        , .sum_comb(sc1), .carry_comb(cc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per lane, a+b as a 2-bit number: bit 0 is the sum, bit 1 the carry.
    function automatic void lane_add(input logic [3:0] x, input logic [3:0] y, input int w,
                                     output logic [3:0] s, output logic [3:0] c);
        int t;
        s = 4'h0;
        c = 4'h0;
        for (int i = 0; i < w; i++) begin
            t    = int'(x[i]) + int'(y[i]);
            s[i] = t[0];
            c[i] = t[1];
        end
    endfunction

    task automatic step();
        logic [3:0] s, c;
        @(posedge clk);
        if (reset) begin
            m_sum4 = 4'h0; m_car4 = 4'h0; m_v4 = 1'b0;
            m_sum1 = 4'h0; m_car1 = 4'h0; m_v1 = 1'b0;
        end else begin
            if (v4) begin
                lane_add(a4, b4, 4, s, c);
                m_sum4 = s; m_car4 = c; m_v4 = 1'b1;
            end else begin
                m_v4 = 1'b0;
            end
            if (v1) begin
                lane_add({3'b000, a1}, {3'b000, b1}, 1, s, c);
                m_sum1 = s; m_car1 = c; m_v1 = 1'b1;
            end else begin
                m_v1 = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({ov4, s4, c4} !== {1'b0, 4'h0, 4'h0}) begin
                errors++;
                $display("FAIL reset4 cyc%0d: got v=%b s=%h c=%h, want v=0 s=0 c=0", k, ov4, s4, c4);
            end
            checks++;
            if ({ov1, s1, c1} !== 3'b000) begin
                errors++;
                $display("FAIL reset1 cyc%0d: got v=%b s=%b c=%b, want 000", k, ov1, s1, c1);
            end
        end
        reset = 1'b0;
        v4 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [1:0] want [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        logic [1:0] ab;
        for (int k = 0; k < 4; k++) begin
            ab = 2'(k);
            v1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            step();
            checks++;
            if ({ov1, s1, c1} !== {1'b1, want[k]}) begin
                errors++;
                $display("FAIL exhaustive ab=%b: got v=%b sc=%b%b, want v=1 sc=%b", ab, ov1, s1, c1, want[k]);
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_lanes();
        v4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        step();
        checks++;
        if ({ov4, s4, c4} !== {1'b1, 4'b0110, 4'b1000}) begin
            errors++;
            $display("FAIL lanes: got v=%b s=%b c=%b, want v=1 s=0110 c=1000", ov4, s4, c4);
        end
    endtask

    task automatic test_hold();
        v4 = 1'b0; a4 = 4'h5; b4 = 4'hA;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({ov4, s4, c4} !== {1'b0, 4'b0110, 4'b1000}) begin
                errors++;
                $display("FAIL hold cyc%0d: got v=%b s=%b c=%b, want v=0 s=0110 c=1000", k, ov4, s4, c4);
            end
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; v4 = 1'b1; a4 = 4'hF; b4 = 4'h1;
        step();
        checks++;
        if ({ov4, s4, c4} !== {1'b0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL rst_prio: got v=%b s=%h c=%h, want v=0 s=0 c=0", ov4, s4, c4);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({ov4, s4, c4} !== {1'b1, 4'hE, 4'h1}) begin
            errors++;
            $display("FAIL rst_release: got v=%b s=%h c=%h, want v=1 s=e c=1", ov4, s4, c4);
        end
        v4 = 1'b0;
    endtask

    task automatic test_comb();
`ifdef HALF_ADDER_COMB_OUT_EN
        v4 = 1'b1; a4 = 4'h3; b4 = 4'h6;
        #1;
        checks++;
        if ({sc4, cc4} !== {4'h5, 4'h2}) begin
            errors++;
            $display("FAIL comb: got sc=%h cc=%h, want sc=5 cc=2", sc4, cc4);
        end
        step();
        checks++;
        if ({ov4, s4, c4} !== {1'b1, 4'h5, 4'h2}) begin
            errors++;
            $display("FAIL comb_reg: got v=%b s=%h c=%h, want v=1 s=5 c=2", ov4, s4, c4);
        end
        v4 = 1'b0;
`endif
    endtask

    task automatic test_random_stream();
        for (int k = 0; k < 200; k++) begin
            reset = ($urandom_range(0, 19) == 0);
            v4 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom);
            step();
            checks++;
            if ({ov4, s4, c4} !== {m_v4, m_sum4, m_car4}) begin
                errors++;
                $display("FAIL rand4 #%0d: got v=%b s=%h c=%h, want v=%b s=%h c=%h",
                         k, ov4, s4, c4, m_v4, m_sum4, m_car4);
            end
            checks++;
            if ({ov1, s1, c1} !== {m_v1, m_sum1[0], m_car1[0]}) begin
                errors++;
                $display("FAIL rand1 #%0d: got v=%b s=%b c=%b, want v=%b s=%b c=%b",
                         k, ov1, s1, c1, m_v1, m_sum1[0], m_car1[0]);
            end
            if (ov4) begin
                checks++;
                if ((s4 & c4) !== 4'h0) begin
                    errors++;
                    $display("FAIL invariant #%0d: sum&carry=%h, want 0", k, s4 & c4);
                end
            end
        end
        reset = 1'b0;
        v4 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        v4 = 1'b0; v1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; a1 = 1'b0; b1 = 1'b0;
        m_sum4 = 4'h0; m_car4 = 4'h0; m_v4 = 1'b0;
        m_sum1 = 4'h0; m_car1 = 4'h0; m_v1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_exhaustive();
        test_lanes();
        test_hold();
        test_reset_priority();
        test_comb();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
